fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the pipelined core; the block sits beside the ID stage.
- It keeps its own in-flight destination scoreboard: a shift register of issued instructions, one entry per stage from EX to WB. Downstream pipeline registers do not feed destinations in.
- Outputs are registered ALU operand-forward selects, a store-data forward, a branch-operand bypass, and a combinational ID stall (load-use and branch-in-ID hazards).
- Includes flush support and a saturating stall-cycle counter.

---
 rtl/fwd_pkg.sv | 28 ++
 rtl/fwd_hazard_unit_match.sv | 29 ++
 rtl/fwd_hazard_unit.sv | 113 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard unit.
package fwd_pkg;

    localparam int unsigned SB_REG_W    = 8;  // widest register address an entry can hold
    localparam int unsigned SEL_W_MAX   = 3;  // select width for the deepest legal pipeline
    localparam int unsigned SEL_REGFILE = 0;
    localparam int unsigned STG_EX      = 1;
    localparam int unsigned STG_MEM     = 2;

    typedef struct packed {
        logic                v;
        logic [SB_REG_W-1:0] rd;
        logic                wr;
        logic                load;
        logic                store;
        logic [SB_REG_W-1:0] rt;
    } sb_entry_t;

    // Current stage k becomes stage k+1 when the consumer reaches EX.
    function automatic logic [SEL_W_MAX-1:0] stage_to_sel(input logic [SEL_W_MAX-1:0] stage);
        return stage + SEL_W_MAX'(1);
    endfunction

    function automatic logic is_producer(input sb_entry_t e);
        return e.v & e.wr & (e.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Priority matcher of one ID source register against the in-flight scoreboard.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic [SB_REG_W-1:0]  src,
    input  logic                 use_src,
    input  sb_entry_t            entries [1:DEPTH],
    output logic [SEL_W_MAX-1:0] match_stage,
    output logic                 load_s1,
    output logic                 hit_last
);

    // match_stage: youngest forwardable producer in stages 1..DEPTH-1, 0 = none
    always_comb begin
        match_stage = '0;
        load_s1     = use_src & is_producer(entries[STG_EX]) & entries[STG_EX].load
                      & (entries[STG_EX].rd == src);
        hit_last    = use_src & is_producer(entries[DEPTH]) & (entries[DEPTH].rd == src);
        for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
            if (use_src && is_producer(entries[k]) && (entries[k].rd == src)
                && !((k == int'(STG_EX)) && entries[k].load)) begin
                match_stage = SEL_W_MAX'(k);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit beside ID: private destination scoreboard,
// registered forward selects, combinational ID stall and branch bypass.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_W = 4,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SEL_W = $clog2(DEPTH + 1),
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             id_store,
    input  logic             id_branch,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_a,
    output logic [SEL_W-1:0] fwd_b,
    output logic             fwd_mem,
    output logic             fwd_br_a,
    output logic             fwd_br_b,
    output logic [CNT_W-1:0] stall_cnt
);

    sb_entry_t             sb [1:DEPTH];
    sb_entry_t             id_entry;
    logic [SB_REG_W-1:0]   rs_x;
    logic [SB_REG_W-1:0]   rt_x;
    logic [SEL_W_MAX-1:0]  a_stage;
    logic [SEL_W_MAX-1:0]  b_stage;
    logic                  a_load_s1;
    logic                  b_load_s1;
    logic                  a_hit_last;
    logic                  b_hit_last;
    logic                  load_use;
    logic                  br_hazard;
    logic                  issue;

    assign rs_x = SB_REG_W'(id_rs);
    assign rt_x = SB_REG_W'(id_rt);

    fwd_match #(.DEPTH(DEPTH)) u_match_rs (
        .src         (rs_x),
        .use_src     (id_use_rs),
        .entries     (sb),
        .match_stage (a_stage),
        .load_s1     (a_load_s1),
        .hit_last    (a_hit_last)
    );

    fwd_match #(.DEPTH(DEPTH)) u_match_rt (
        .src         (rt_x),
        .use_src     (id_use_rt),
        .entries     (sb),
        .match_stage (b_stage),
        .load_s1     (b_load_s1),
        .hit_last    (b_hit_last)
    );

    // Store data on rt is not a load-use hazard: the MEM/WB store-data path covers it.
    always_comb begin
        load_use  = a_load_s1 | (b_load_s1 & ~id_store);
        br_hazard = id_branch & (a_load_s1 | b_load_s1 | (a_stage != '0) | (b_stage != '0));
        stall     = id_valid & (load_use | br_hazard);
        fwd_br_a  = id_valid & id_branch & ~stall & a_hit_last;
        fwd_br_b  = id_valid & id_branch & ~stall & b_hit_last;
        issue     = id_valid & ~stall & ~flush;

        id_entry       = '0;
        id_entry.v     = 1'b1;
        id_entry.rd    = SB_REG_W'(id_rd);
        id_entry.wr    = id_wr;
        id_entry.load  = id_load;
        id_entry.store = id_store;
        id_entry.rt    = rt_x;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                sb[k] <= '0;
            end
            fwd_a     <= SEL_W'(SEL_REGFILE);
            fwd_b     <= SEL_W'(SEL_REGFILE);
            fwd_mem   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            sb[STG_EX] <= issue ? id_entry : '0;
            for (int k = 2; k <= int'(DEPTH); k++) begin
                sb[k] <= sb[k-1];
            end
            fwd_a <= (issue && (a_stage != '0)) ? SEL_W'(stage_to_sel(a_stage))
                                                : SEL_W'(SEL_REGFILE);
            fwd_b <= (issue && (b_stage != '0)) ? SEL_W'(stage_to_sel(b_stage))
                                                : SEL_W'(SEL_REGFILE);
            // Store about to enter EX/MEM with its data load about to enter MEM/WB
            fwd_mem <= sb[STG_EX].v & sb[STG_EX].store & is_producer(sb[DEPTH-1])
                       & sb[DEPTH-1].load & (sb[DEPTH-1].rd == sb[STG_EX].rt);
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: DEPTH=3 and DEPTH=5 units driven in parallel against a queue-based reference.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr = 1'b0;
    logic       id_load = 1'b0, id_store = 1'b0, id_branch = 1'b0, flush = 1'b0;

    logic        stall3, fm3, bra3, brb3;
    logic [1:0]  fa3, fb3;
    logic [15:0] cnt3;
    logic        stall5, fm5, bra5, brb5;
    logic [2:0]  fa5, fb5;
    logic [3:0]  cnt5;

    fwd_hazard_unit #(.REG_W(4), .DEPTH(3), .CNT_W(16)) u_d3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr),
        .id_load(id_load), .id_store(id_store), .id_branch(id_branch), .flush(flush),
        .stall(stall3), .fwd_a(fa3), .fwd_b(fb3), .fwd_mem(fm3), .fwd_br_a(bra3),
        .fwd_br_b(brb3), .stall_cnt(cnt3)
    );

    fwd_hazard_unit #(.REG_W(4), .DEPTH(5), .CNT_W(4)) u_d5 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr),
        .id_load(id_load), .id_store(id_store), .id_branch(id_branch), .flush(flush),
        .stall(stall5), .fwd_a(fa5), .fwd_b(fb5), .fwd_mem(fm5), .fwd_br_a(bra5),
        .fwd_br_b(brb5), .stall_cnt(cnt5)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit v; int rs; int rt; int rd;
        bit use_rs; bit use_rt; bit wr; bit load; bit store; bit branch; bit flush; bit rst;
    } instr_t;

    typedef struct {
        bit stall; bit br_a; bit br_b; bit fm; int fa; int fb; int cnt;
    } exp_t;

    // hist[m][k] = instruction that occupies stage k of model m (v=0 means bubble)
    instr_t hist [2][1:6];
    int     depth [2]   = '{3, 5};
    int     cnt_max [2] = '{65535, 15};
    int     cnt_m [2]   = '{0, 0};
    exp_t   q3[$], q5[$];
    int     n_tests = 0, n_fail = 0;
    bit     last_stall3 = 1'b0;

    function automatic bit prod(input instr_t e);
        return e.v && e.wr && (e.rd != 0);
    endfunction

    function automatic bit reads(input instr_t s, input int r);
        return (s.use_rs && s.rs == r) || (s.use_rt && s.rt == r);
    endfunction

    function automatic int youngest(input int m, input int src, input bit use_src);
        if (!use_src) return 0;
        for (int k = 1; k < depth[m]; k++) begin
            if (prod(hist[m][k]) && hist[m][k].rd == src && !(k == 1 && hist[m][k].load))
                return k + 1;
        end
        return 0;
    endfunction

    function automatic exp_t model_step(input int m, input instr_t s);
        exp_t   e;
        instr_t h1, hl, hm, bubble;
        int     d;
        bit     lu, bh, issue;
        d = depth[m];
        e = '{default: 0};
        bubble = '{default: 0};
        h1 = hist[m][1];
        hl = hist[m][d];
        hm = hist[m][d-1];
        lu = s.v && prod(h1) && h1.load &&
             ((s.use_rs && h1.rd == s.rs) || (s.use_rt && !s.store && h1.rd == s.rt));
        bh = 1'b0;
        if (s.v && s.branch) begin
            for (int k = 1; k < d; k++)
                if (prod(hist[m][k]) && reads(s, hist[m][k].rd)) bh = 1'b1;
        end
        e.stall = lu || bh;
        e.br_a  = s.v && s.branch && !e.stall && s.use_rs && prod(hl) && hl.rd == s.rs;
        e.br_b  = s.v && s.branch && !e.stall && s.use_rt && prod(hl) && hl.rd == s.rt;
        issue   = s.v && !e.stall && !s.flush;
        e.fa    = issue ? youngest(m, s.rs, s.use_rs) : 0;
        e.fb    = issue ? youngest(m, s.rt, s.use_rt) : 0;
        e.fm    = h1.v && h1.store && prod(hm) && hm.load && hm.rd == h1.rt;
        if (s.rst) begin
            e.fa = 0; e.fb = 0; e.fm = 1'b0;
            cnt_m[m] = 0;
            for (int k = 1; k <= 6; k++) hist[m][k] = bubble;
        end else begin
            if (e.stall && cnt_m[m] < cnt_max[m]) cnt_m[m]++;
            for (int k = d; k >= 2; k--) hist[m][k] = hist[m][k-1];
            hist[m][1] = issue ? s : bubble;
        end
        e.cnt = cnt_m[m];
        return e;
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endfunction

    task automatic step(input instr_t s);
        exp_t e3, e5;
        @(posedge clk); #2;
        rst_n     = s.rst ? 1'b0 : 1'b1;
        id_valid  = s.v;
        id_rs     = 4'(s.rs);
        id_rt     = 4'(s.rt);
        id_rd     = 4'(s.rd);
        id_use_rs = s.use_rs;
        id_use_rt = s.use_rt;
        id_wr     = s.wr;
        id_load   = s.load;
        id_store  = s.store;
        id_branch = s.branch;
        flush     = s.flush;
        e3 = model_step(0, s);
        e5 = model_step(1, s);
        q3.push_back(e3);
        q5.push_back(e5);
        last_stall3 = e3.stall;
    endtask

    // Re-present the ID instruction while the DEPTH=3 unit holds IF/ID
    task automatic issue_hold(input instr_t s);
        step(s);
        for (int i = 0; i < 8 && last_stall3; i++) step(s);
    endtask

    function automatic instr_t nop();
        instr_t r = '{default: 0};
        return r;
    endfunction

    function automatic instr_t alu(input int rd, input int rs, input int rt);
        instr_t r = '{default: 0};
        r.v = 1; r.rd = rd; r.rs = rs; r.rt = rt; r.use_rs = 1; r.use_rt = 1; r.wr = 1;
        return r;
    endfunction

    function automatic instr_t lw(input int rd, input int rs);
        instr_t r = '{default: 0};
        r.v = 1; r.rd = rd; r.rs = rs; r.use_rs = 1; r.wr = 1; r.load = 1;
        return r;
    endfunction

    function automatic instr_t sw(input int rt, input int rs);
        instr_t r = '{default: 0};
        r.v = 1; r.rt = rt; r.rs = rs; r.use_rs = 1; r.use_rt = 1; r.store = 1;
        return r;
    endfunction

    function automatic instr_t beq(input int rs, input int rt);
        instr_t r = '{default: 0};
        r.v = 1; r.rs = rs; r.rt = rt; r.use_rs = 1; r.use_rt = 1; r.branch = 1;
        return r;
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        int     kind;
        kind = int'($urandom_range(0, 4));
        case (kind)
            0:       r = alu(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            1:       r = lw(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            2:       r = sw(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            3:       r = beq(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            default: begin
                r = alu(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
                r.use_rt = 0;
            end
        endcase
        r.v     = ($urandom_range(0, 7) != 0);
        r.flush = ($urandom_range(0, 15) == 0);
        r.rst   = ($urandom_range(0, 63) == 0);
        return r;
    endfunction

    // Monitor: comb outputs sampled mid-cycle, registered outputs just after the edge
    exp_t m3, m5;
    int   c_st3, c_ba3, c_bb3, c_st5, c_ba5, c_bb5;
    initial forever begin
        @(negedge clk);
        if (q3.size() != 0 && q5.size() != 0) begin
            m3 = q3.pop_front();
            m5 = q5.pop_front();
            c_st3 = int'(stall3); c_ba3 = int'(bra3); c_bb3 = int'(brb3);
            c_st5 = int'(stall5); c_ba5 = int'(bra5); c_bb5 = int'(brb5);
            @(posedge clk); #1;
            chk("d3_stall",    c_st3,       int'(m3.stall));
            chk("d3_fwd_br_a", c_ba3,       int'(m3.br_a));
            chk("d3_fwd_br_b", c_bb3,       int'(m3.br_b));
            chk("d3_fwd_a",    int'(fa3),   m3.fa);
            chk("d3_fwd_b",    int'(fb3),   m3.fb);
            chk("d3_fwd_mem",  int'(fm3),   int'(m3.fm));
            chk("d3_stall_cnt",int'(cnt3),  m3.cnt);
            chk("d5_stall",    c_st5,       int'(m5.stall));
            chk("d5_fwd_br_a", c_ba5,       int'(m5.br_a));
            chk("d5_fwd_br_b", c_bb5,       int'(m5.br_b));
            chk("d5_fwd_a",    int'(fa5),   m5.fa);
            chk("d5_fwd_b",    int'(fb5),   m5.fb);
            chk("d5_fwd_mem",  int'(fm5),   int'(m5.fm));
            chk("d5_stall_cnt",int'(cnt5),  m5.cnt);
        end
    end

    initial begin
        instr_t cur, tmp;
        for (int m = 0; m < 2; m++)
            for (int k = 1; k <= 6; k++) hist[m][k] = '{default: 0};
        repeat (2) @(posedge clk);

        // reset state with idle ID
        step(nop()); step(nop());
        // back-to-back ALU dependency, then one gap
        step(alu(1, 2, 3)); step(alu(2, 1, 3)); step(nop());
        step(alu(1, 2, 3)); step(alu(8, 9, 10)); step(alu(5, 1, 9)); step(nop());
        // load-use
        step(lw(4, 0)); issue_hold(alu(5, 4, 4)); step(nop());
        // load feeding store data
        step(lw(6, 0)); step(sw(6, 7)); step(nop()); step(nop());
        // branch in ID after ALU producer, and r0 producers
        step(alu(1, 2, 3)); issue_hold(beq(1, 0)); step(nop());
        step(alu(0, 2, 3)); step(alu(5, 0, 0)); step(beq(0, 0)); step(nop());
        // flushed producer
        tmp = alu(1, 2, 3); tmp.flush = 1;
        step(tmp); step(alu(5, 1, 1)); step(nop());
        // reset during a load-use stall
        step(lw(4, 0)); step(alu(5, 4, 4));
        tmp = alu(5, 4, 4); tmp.rst = 1;
        step(tmp); step(alu(5, 4, 4)); step(nop());
        // forward-distance sweep and youngest-match priority
        for (int g = 0; g < 4; g++) begin
            step(alu(1, 2, 3));
            repeat (g) step(nop());
            step(alu(5, 1, 1));
            repeat (4) step(nop());
        end
        step(alu(1, 2, 3)); step(alu(1, 3, 3)); step(alu(5, 1, 0)); repeat (4) step(nop());
        // saturate the narrow stall counter
        for (int i = 0; i < 6; i++) begin
            step(alu(1, 2, 3)); issue_hold(beq(1, 0));
        end
        repeat (4) step(nop());

        // randomized traffic; held instructions model IF/ID freeze
        cur = nop();
        for (int i = 0; i < 600; i++) begin
            if (!last_stall3 || $urandom_range(0, 7) == 0) cur = rand_instr();
            step(cur);
        end

        repeat (3) @(posedge clk);
        #5;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
